// File: rtl/switch_pulse_sequencer_pkg.sv
// Shared types and defaults for the photonic-switch pulse sequencer.
package switch_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DELAY = 3'd1,
      SET   = 3'd2,
      HOLD  = 3'd3,
      RST   = 3'd4
   } chan_state_t;

   localparam int PULSE_W_DEF = 4;
   localparam int DEAD_T_DEF  = 2;

endpackage

// File: rtl/switch_pulse_sequencer_if.sv
// Trigger/config inputs and per-switch pulse outputs of the sequencer.
interface switch_pulse_sequencer_if #(
   parameter int NUM_SW = 4,
   parameter int CNT_W  = 16
);
   logic                      trig;
   logic                      abort;
   logic [NUM_SW*CNT_W-1:0]   on_dly;
   logic [NUM_SW*CNT_W-1:0]   on_len;
   logic [NUM_SW-1:0]         sw_set;
   logic [NUM_SW-1:0]         sw_rst;
   logic [NUM_SW-1:0]         sw_on;
   logic                      busy;
   logic                      trig_drop;

   modport master (
      output trig, abort, on_dly, on_len,
      input  sw_set, sw_rst, sw_on, busy, trig_drop
   );

   modport slave (
      input  trig, abort, on_dly, on_len,
      output sw_set, sw_rst, sw_on, busy, trig_drop
   );
endinterface

// File: rtl/switch_pulse_sequencer_channel.sv
// One switch channel: DELAY -> SET -> HOLD -> RST sequence with abort handling.
module switch_pulse_channel
   import switch_seq_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int PULSE_W = PULSE_W_DEF,
   parameter int DEAD_T  = DEAD_T_DEF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [CNT_W-1:0] i_onDly,
   input  logic [CNT_W-1:0] i_onLen,
   output logic             o_set,
   output logic             o_rst,
   output logic             o_on,
   output logic             o_active
);

   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] DEAD_LEN   = CNT_W'(DEAD_T);
   localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_T - 1);
   localparam logic [CNT_W-1:0] DEAD_CAP   = CNT_W'((DEAD_T >= 2) ? (DEAD_T - 2) : 0);

   chan_state_t      r_state, w_stateNext;
   logic [CNT_W-1:0] r_cnt, w_cntNext;
   logic [CNT_W-1:0] r_len, w_lenNext;
   logic [CNT_W-1:0] w_holdLast;
   logic             r_abortSeen, w_abortSeenNext;
   logic             r_set, r_rst, r_on;

   // Counters hold "cycles remaining minus one", so a full 2^CNT_W-1 delay fits without wrap.
   assign w_holdLast = (r_len > DEAD_LEN) ? (r_len - ONE) : DEAD_LAST;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_len       <= '0;
         r_abortSeen <= 1'b0;
         r_set       <= 1'b0;
         r_rst       <= 1'b0;
         r_on        <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_cnt       <= w_cntNext;
         r_len       <= w_lenNext;
         r_abortSeen <= w_abortSeenNext;
         r_set       <= (w_stateNext == SET);
         r_rst       <= (w_stateNext == RST);
         r_on        <= (w_stateNext == SET) || (w_stateNext == HOLD);
      end
   end

   // An abort seen during SET is remembered so the following HOLD uses DEAD_T instead of on_len.
   always_comb begin
      w_stateNext     = r_state;
      w_cntNext       = r_cnt;
      w_lenNext       = r_len;
      w_abortSeenNext = r_abortSeen;
      case (r_state)
         IDLE: begin
            w_abortSeenNext = 1'b0;
            if (i_start && !i_abort) begin
               w_lenNext = i_onLen;
               if (i_onDly == '0) begin
                  w_stateNext = SET;
                  w_cntNext   = PULSE_LAST;
               end else begin
                  w_stateNext = DELAY;
                  w_cntNext   = i_onDly - ONE;
               end
            end
         end
         DELAY: begin
            if (i_abort) begin
               w_stateNext = IDLE;
               w_cntNext   = '0;
            end else if (r_cnt == '0) begin
               w_stateNext = SET;
               w_cntNext   = PULSE_LAST;
            end else begin
               w_cntNext = r_cnt - ONE;
            end
         end
         SET: begin
            if (i_abort) w_abortSeenNext = 1'b1;
            if (r_cnt == '0) begin
               w_stateNext = HOLD;
               w_cntNext   = (i_abort || r_abortSeen) ? DEAD_LAST : w_holdLast;
            end else begin
               w_cntNext = r_cnt - ONE;
            end
         end
         HOLD: begin
            if ((r_cnt == '0) || (i_abort && (DEAD_T == 1))) begin
               w_stateNext = RST;
               w_cntNext   = PULSE_LAST;
            end else if (i_abort && (r_cnt > DEAD_LAST)) begin
               w_cntNext = DEAD_CAP;
            end else begin
               w_cntNext = r_cnt - ONE;
            end
         end
         RST: begin
            if (r_cnt == '0) begin
               w_stateNext = IDLE;
            end else begin
               w_cntNext = r_cnt - ONE;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
         end
      endcase
   end

   assign o_set    = r_set;
   assign o_rst    = r_rst;
   assign o_on     = r_on;
   assign o_active = (r_state != IDLE);

endmodule

// File: rtl/switch_pulse_sequencer.sv
// Top of the switch pulse sequencer: trigger edge detect, busy/trig_drop and channel fan-out.
module switch_pulse_sequencer
   import switch_seq_pkg::*;
#(
   parameter int NUM_SW  = 4,
   parameter int CNT_W   = 16,
   parameter int PULSE_W = PULSE_W_DEF,
   parameter int DEAD_T  = DEAD_T_DEF
)(
   input logic                       clk,
   input logic                       reset,
   switch_pulse_sequencer_if.slave   bus
);

   logic              r_trigPrevLow;
   logic              r_busy;
   logic              r_trigDrop;
   logic              w_edge;
   logic              w_start;
   logic [NUM_SW-1:0] w_set, w_rst, w_on, w_active;

   // History resets to "not low", so a trigger held high across reset release is not an edge.
   assign w_edge  = bus.trig & r_trigPrevLow;
   assign w_start = w_edge & ~r_busy & ~bus.abort;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_trigPrevLow <= 1'b0;
         r_busy        <= 1'b0;
         r_trigDrop    <= 1'b0;
      end else begin
         r_trigPrevLow <= ~bus.trig;
         r_busy        <= w_start | (|w_active);
         r_trigDrop    <= w_edge & r_busy & ~bus.abort;
      end
   end

   for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
      switch_pulse_channel #(
         .CNT_W   (CNT_W),
         .PULSE_W (PULSE_W),
         .DEAD_T  (DEAD_T)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .i_start  (w_start),
         .i_abort  (bus.abort),
         .i_onDly  (bus.on_dly[i*CNT_W +: CNT_W]),
         .i_onLen  (bus.on_len[i*CNT_W +: CNT_W]),
         .o_set    (w_set[i]),
         .o_rst    (w_rst[i]),
         .o_on     (w_on[i]),
         .o_active (w_active[i])
      );
   end

   assign bus.sw_set    = w_set;
   assign bus.sw_rst    = w_rst;
   assign bus.sw_on     = w_on;
   assign bus.busy      = r_busy;
   assign bus.trig_drop = r_trigDrop;

   assert property (@(posedge clk) disable iff (reset) ((w_set & w_rst) == '0));

endmodule

// File: tb/tb_switch_pulse_sequencer.sv
// Directed bench for switch_pulse_sequencer: per-cycle masks compared against hand-derived timelines.
module tb_switch_pulse_sequencer;
   import switch_seq_pkg::*;

   localparam int NUM_SW = 4;
   localparam int CNT_W  = 16;

   logic clk = 1'b0;
   logic reset;
   int   testsRun    = 0;
   int   testsFailed = 0;

   logic [63:0] setM [NUM_SW];
   logic [63:0] rstM [NUM_SW];
   logic [63:0] onM  [NUM_SW];
   logic [63:0] busyM;
   logic [63:0] dropM;
   int          overlapCnt;

   switch_pulse_sequencer_if #(.NUM_SW(NUM_SW), .CNT_W(CNT_W)) bus ();

   switch_pulse_sequencer #(
      .NUM_SW  (NUM_SW),
      .CNT_W   (CNT_W),
      .PULSE_W (4),
      .DEAD_T  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic setChan(input int ch, input logic [15:0] dly, input logic [15:0] len);
      bus.on_dly[ch*CNT_W +: CNT_W] = dly;
      bus.on_len[ch*CNT_W +: CNT_W] = len;
   endtask

   // Offset 0 is the cycle in which trig was raised; bit k of each mask is the value in cycle k.
   task automatic applyStimulus(input int n, input int retrigAt, input int abortAt,
                                input logic holdTrig, input logic scramble);
      for (int c = 0; c < NUM_SW; c++) begin
         setM[c] = '0; rstM[c] = '0; onM[c] = '0;
      end
      busyM = '0; dropM = '0; overlapCnt = 0;
      for (int k = 1; k <= n; k++) begin
         tick();
         for (int c = 0; c < NUM_SW; c++) begin
            setM[c][k] = bus.sw_set[c];
            rstM[c][k] = bus.sw_rst[c];
            onM[c][k]  = bus.sw_on[c];
         end
         busyM[k] = bus.busy;
         dropM[k] = bus.trig_drop;
         if ((bus.sw_set & bus.sw_rst) != '0) overlapCnt++;
         bus.trig  = holdTrig || (k == retrigAt);
         bus.abort = (k == abortAt);
         if (scramble && k == 1) begin
            bus.on_dly = {NUM_SW{16'h0009}};
            bus.on_len = {NUM_SW{16'h0009}};
         end
      end
   endtask

   task automatic waitIdle(input string name);
      int c = 0;
      bus.trig  = 1'b0;
      bus.abort = 1'b0;
      while (bus.busy && c < 200) begin
         tick();
         c++;
      end
      testsRun++;
      if (bus.busy) begin
         testsFailed++;
         $display("[TB] FAIL %s_idle_timeout busy=%b want 0", name, bus.busy);
      end
      tick();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.trig = 1'b0; bus.abort = 1'b0;
      bus.on_dly = '0; bus.on_len = '0;
      #1;
      testsRun++;
      if ({bus.sw_set, bus.sw_rst, bus.sw_on} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL reset_outputs got %h want 0", {bus.sw_set, bus.sw_rst, bus.sw_on});
      end
      testsRun++;
      if ({bus.busy, bus.trig_drop} !== 2'b00) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags got %b want 00", {bus.busy, bus.trig_drop});
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      tick(); tick();
      testsRun++;
      if (bus.busy !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_release_busy got %b want 0", bus.busy);
      end
   endtask

   task automatic test_basic;
      setChan(0, 16'd3, 16'd5);
      for (int c = 1; c < NUM_SW; c++) setChan(c, 16'd0, 16'd0);
      bus.trig = 1'b1;
      applyStimulus(24, -1, -1, 1'b0, 1'b1);
      testsRun++;
      if (setM[0] !== 64'h0000_00F0) begin
         testsFailed++; $display("[TB] FAIL basic_set0 got %h want %h", setM[0], 64'h00F0);
      end
      testsRun++;
      if (rstM[0] !== 64'h0001_E000) begin
         testsFailed++; $display("[TB] FAIL basic_rst0 got %h want %h", rstM[0], 64'h1E000);
      end
      testsRun++;
      if (onM[0] !== 64'h0000_1FF0) begin
         testsFailed++; $display("[TB] FAIL basic_on0 got %h want %h", onM[0], 64'h1FF0);
      end
      testsRun++;
      if (busyM !== 64'h0003_FFFE) begin
         testsFailed++; $display("[TB] FAIL basic_busy got %h want %h", busyM, 64'h3FFFE);
      end
      testsRun++;
      if ({setM[1], rstM[1]} !== {64'h1E, 64'h780}) begin
         testsFailed++; $display("[TB] FAIL basic_ch1 got %h/%h want 1e/780", setM[1], rstM[1]);
      end
      testsRun++;
      if (dropM !== 64'h0) begin
         testsFailed++; $display("[TB] FAIL basic_drop got %h want 0", dropM);
      end
      waitIdle("basic");
   endtask

   task automatic test_zero_min;
      for (int c = 0; c < NUM_SW; c++) setChan(c, 16'd0, 16'd0);
      bus.trig = 1'b1;
      applyStimulus(14, -1, -1, 1'b0, 1'b0);
      for (int c = 0; c < NUM_SW; c++) begin
         testsRun++;
         if (setM[c] !== 64'h1E || rstM[c] !== 64'h780) begin
            testsFailed++;
            $display("[TB] FAIL zero_ch%0d got set %h rst %h want 1e/780", c, setM[c], rstM[c]);
         end
      end
      testsRun++;
      if (busyM !== 64'hFFE) begin
         testsFailed++; $display("[TB] FAIL zero_busy got %h want ffe", busyM);
      end
      testsRun++;
      if (overlapCnt !== 0) begin
         testsFailed++; $display("[TB] FAIL zero_overlap got %0d want 0", overlapCnt);
      end
      waitIdle("zero");
   endtask

   task automatic test_back_to_back;
      setChan(0, 16'd3, 16'd5);
      for (int c = 1; c < NUM_SW; c++) setChan(c, 16'd0, 16'd0);
      bus.trig = 1'b1;
      applyStimulus(24, 5, -1, 1'b0, 1'b0);
      testsRun++;
      if (dropM !== 64'h40) begin
         testsFailed++; $display("[TB] FAIL retrig_drop got %h want 40", dropM);
      end
      testsRun++;
      if (setM[0] !== 64'hF0 || rstM[0] !== 64'h1E000) begin
         testsFailed++; $display("[TB] FAIL retrig_ch0 got %h/%h want f0/1e000", setM[0], rstM[0]);
      end
      testsRun++;
      if (busyM !== 64'h3FFFE) begin
         testsFailed++; $display("[TB] FAIL retrig_busy got %h want 3fffe", busyM);
      end
      waitIdle("retrig");
   endtask

   task automatic test_abort_delay;
      setChan(0, 16'd40, 16'd0);
      setChan(1, 16'd0, 16'd30);
      setChan(2, 16'd0, 16'd0);
      setChan(3, 16'd0, 16'd0);
      bus.trig = 1'b1;
      applyStimulus(26, -1, 15, 1'b0, 1'b0);
      testsRun++;
      if (setM[0] !== 64'h0 || rstM[0] !== 64'h0) begin
         testsFailed++; $display("[TB] FAIL abortdly_ch0 got %h/%h want 0/0", setM[0], rstM[0]);
      end
      testsRun++;
      if (rstM[1] !== 64'h1E_0000) begin
         testsFailed++; $display("[TB] FAIL abortdly_rst1 got %h want 1e0000", rstM[1]);
      end
      testsRun++;
      if (onM[1] !== 64'h1_FFFE) begin
         testsFailed++; $display("[TB] FAIL abortdly_on1 got %h want 1fffe", onM[1]);
      end
      testsRun++;
      if (busyM !== 64'h3F_FFFE) begin
         testsFailed++; $display("[TB] FAIL abortdly_busy got %h want 3ffffe", busyM);
      end
      waitIdle("abortdly");
   endtask

   task automatic test_abort_set;
      setChan(0, 16'd0, 16'd30);
      for (int c = 1; c < NUM_SW; c++) setChan(c, 16'd0, 16'd0);
      bus.trig = 1'b1;
      applyStimulus(14, -1, 3, 1'b0, 1'b0);
      testsRun++;
      if (setM[0] !== 64'h1E) begin
         testsFailed++; $display("[TB] FAIL abortset_set0 got %h want 1e", setM[0]);
      end
      testsRun++;
      if (rstM[0] !== 64'h780) begin
         testsFailed++; $display("[TB] FAIL abortset_rst0 got %h want 780", rstM[0]);
      end
      testsRun++;
      if (onM[0] !== 64'h7E) begin
         testsFailed++; $display("[TB] FAIL abortset_on0 got %h want 7e", onM[0]);
      end
      testsRun++;
      if (busyM !== 64'hFFE) begin
         testsFailed++; $display("[TB] FAIL abortset_busy got %h want ffe", busyM);
      end
      waitIdle("abortset");
   endtask

   task automatic test_abort_with_edge;
      for (int c = 0; c < NUM_SW; c++) setChan(c, 16'd0, 16'd0);
      bus.trig  = 1'b1;
      bus.abort = 1'b1;
      applyStimulus(8, -1, -1, 1'b0, 1'b0);
      testsRun++;
      if (busyM !== 64'h0 || setM[0] !== 64'h0) begin
         testsFailed++; $display("[TB] FAIL abortedge_start got busy %h set %h want 0/0", busyM, setM[0]);
      end
      testsRun++;
      if (dropM !== 64'h0) begin
         testsFailed++; $display("[TB] FAIL abortedge_drop got %h want 0", dropM);
      end
      waitIdle("abortedge");
   endtask

   task automatic test_async_reset;
      for (int c = 0; c < NUM_SW; c++) setChan(c, 16'd0, 16'd0);
      bus.trig = 1'b1;
      applyStimulus(8, -1, -1, 1'b0, 1'b0);
      testsRun++;
      if (rstM[0] !== 64'h180) begin
         testsFailed++; $display("[TB] FAIL areset_pre_rst got %h want 180", rstM[0]);
      end
      bus.trig = 1'b1;
      #2 reset = 1'b1;
      #1;
      testsRun++;
      if ({bus.sw_set, bus.sw_rst, bus.sw_on, bus.busy, bus.trig_drop} !== '0) begin
         testsFailed++;
         $display("[TB] FAIL areset_outputs got %h want 0",
                  {bus.sw_set, bus.sw_rst, bus.sw_on, bus.busy, bus.trig_drop});
      end
      tick(); tick();
      reset = 1'b0;
      applyStimulus(10, -1, -1, 1'b1, 1'b0);
      testsRun++;
      if (busyM !== 64'h0 || setM[0] !== 64'h0) begin
         testsFailed++; $display("[TB] FAIL areset_held_trig got busy %h set %h want 0/0", busyM, setM[0]);
      end
      bus.trig = 1'b0;
      tick();
      bus.trig = 1'b1;
      applyStimulus(14, -1, -1, 1'b0, 1'b0);
      testsRun++;
      if (setM[0] !== 64'h1E || rstM[0] !== 64'h780) begin
         testsFailed++; $display("[TB] FAIL areset_restart got %h/%h want 1e/780", setM[0], rstM[0]);
      end
      waitIdle("areset");
   endtask

   task automatic checkOutput;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_min();
      test_back_to_back();
      test_abort_delay();
      test_abort_set();
      test_abort_with_edge();
      test_async_reset();
      checkOutput();
      $finish;
   end

endmodule
